// File: rtl/link_pattern_pkg.sv
// Shared types and the PRBS7 byte-step function for the link test-pattern generator.
package link_pattern_pkg;

  typedef enum logic [1:0] {
    FIXED  = 2'd0,
    PRBS7  = 2'd1,
    COUNT  = 2'd2,
    TOGGLE = 2'd3
  } pattern_mode_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } gen_state_t;

  localparam logic [6:0] PRBS7_DEFAULT_SEED = 7'h7F;

  typedef struct packed {
    logic [6:0] next_state;
    logic [7:0] word;
  } prbs7_step_t;

  // x^7+x^6+1, eight serial steps; the first generated bit lands in word[0].
  function automatic prbs7_step_t prbs7_step8(input logic [6:0] s);
    prbs7_step_t r;
    logic [6:0]  st;
    logic        bit_out;
    st     = s;
    r.word = '0;
    for (int i = 0; i < 8; i++) begin
      bit_out   = st[6] ^ st[5];
      r.word[i] = bit_out;
      st        = {st[5:0], bit_out};
    end
    r.next_state = st;
    return r;
  endfunction

endpackage

// File: rtl/prbs7_byte_gen.sv
// PRBS7 LFSR register; word is the byte generated from the current state and
// the state moves forward by eight bits on each advance.
module prbs7_byte_gen
  import link_pattern_pkg::*;
#(
  parameter logic [6:0] RESET_SEED = PRBS7_DEFAULT_SEED
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [6:0] seed,
  input  logic       advance,
  output logic [7:0] word
);

  logic [6:0]  lfsr;
  prbs7_step_t step;

  assign step = prbs7_step8(lfsr);
  assign word = step.word;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr <= RESET_SEED;
    end else if (load) begin
      lfsr <= seed;
    end else if (advance) begin
      lfsr <= step.next_state;
    end
  end

endmodule

// File: rtl/link_pattern_gen.sv
// Per-link AXI-stream test-pattern source (fixed/PRBS7/count/toggle), bounded or continuous bursts.
// Words hold under backpressure; optional error injection under LINK_PATTERN_GEN_ERR_INJECT_EN.
module link_pattern_gen
  import link_pattern_pkg::*;
#(
  parameter int         COUNTER_WIDTH = 32,
  parameter logic [6:0] PRBS_SEED     = 7'h7F
) (
  input  logic                     clk160,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     stop,
  input  logic [1:0]               mode,
  input  logic [7:0]               fixed_pattern,
  input  logic [COUNTER_WIDTH-1:0] burst_len,
  output logic [7:0]               tdata,
  output logic                     tvalid,
  input  logic                     tready,
  output logic                     busy,
  output logic                     done,
  output logic [COUNTER_WIDTH-1:0] word_count
`ifdef LINK_PATTERN_GEN_ERR_INJECT_EN
  ,
  input  logic                     inject_err,
  output logic [COUNTER_WIDTH-1:0] inject_count
`endif
);

  localparam logic [6:0] SEED = (PRBS_SEED == 7'h00) ? PRBS7_DEFAULT_SEED : PRBS_SEED;
  localparam logic [COUNTER_WIDTH-1:0] COUNT_MAX = '1;

  gen_state_t                state, state_nxt;
  pattern_mode_t             mode_q;
  logic [7:0]                fixed_q;
  logic [COUNTER_WIDTH-1:0]  len_q;
  logic [7:0]                cnt_val;
  logic                      tog_phase;
  logic                      stop_pending;
  logic [COUNTER_WIDTH-1:0]  count_nxt;
  logic [7:0]                prbs_word;
  logic [7:0]                pattern;
  logic                      run, hs, launch, last_word, stop_now, flip;

  assign run       = (state == RUN);
  assign hs        = run && tready;
  assign launch    = !run && start && !stop;
  assign count_nxt = (word_count == COUNT_MAX) ? word_count : word_count + 1'b1;
  assign last_word = hs && (len_q != '0) && (count_nxt == len_q);
  assign stop_now  = hs && (stop_pending || stop);

  always_ff @(posedge clk160 or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start && !stop) state_nxt = RUN;
      RUN: begin
        if (last_word) begin
          state_nxt = DONE;
        end else if (stop_now) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk160 or posedge rst) begin
    if (rst) begin
      mode_q       <= FIXED;
      fixed_q      <= '0;
      len_q        <= '0;
      cnt_val      <= '0;
      tog_phase    <= 1'b0;
      stop_pending <= 1'b0;
      word_count   <= '0;
    end else if (launch) begin
      mode_q       <= pattern_mode_t'(mode);
      fixed_q      <= fixed_pattern;
      len_q        <= burst_len;
      cnt_val      <= '0;
      tog_phase    <= 1'b0;
      stop_pending <= 1'b0;
      word_count   <= '0;
    end else begin
      // Any handshake while a stop is pending ends the burst, so the flag only survives idle cycles.
      stop_pending <= run && !hs && (stop_pending || stop);
      if (hs) begin
        word_count <= count_nxt;
        cnt_val    <= cnt_val + 1'b1;
        tog_phase  <= ~tog_phase;
      end
    end
  end

  prbs7_byte_gen #(
    .RESET_SEED(SEED)
  ) u_prbs (
    .clk     (clk160),
    .rst     (rst),
    .load    (launch),
    .seed    (SEED),
    .advance (hs),
    .word    (prbs_word)
  );

  always_comb begin
    pattern = fixed_q;
    case (mode_q)
      FIXED:   pattern = fixed_q;
      PRBS7:   pattern = prbs_word;
      COUNT:   pattern = cnt_val;
      TOGGLE:  pattern = tog_phase ? ~fixed_q : fixed_q;
      default: pattern = fixed_q;
    endcase
  end

`ifdef LINK_PATTERN_GEN_ERR_INJECT_EN
  logic                     armed;
  logic [COUNTER_WIDTH-1:0] inj_cnt;

  // Corruption is applied on the output only, so the generator sequence is untouched.
  always_ff @(posedge clk160 or posedge rst) begin
    if (rst) begin
      armed   <= 1'b0;
      inj_cnt <= '0;
    end else if (launch) begin
      armed   <= 1'b0;
      inj_cnt <= '0;
    end else begin
      armed <= run && ((armed && !hs) || inject_err);
      if (hs && armed && (inj_cnt != COUNT_MAX)) begin
        inj_cnt <= inj_cnt + 1'b1;
      end
    end
  end

  assign flip         = armed;
  assign inject_count = inj_cnt;
`else
  assign flip = 1'b0;
`endif

  assign tdata  = run ? (pattern ^ {7'b0, flip}) : 8'h00;
  assign tvalid = run;
  assign busy   = run;
  assign done   = last_word;

endmodule

// File: tb/tb_link_pattern_gen.sv
// Directed bench for link_pattern_gen: PRBS, counting, toggle, stop, reset and optional injection.
module tb_link_pattern_gen;

  logic        clk160;
  logic        rst;
  logic        start;
  logic        stop;
  logic [1:0]  mode;
  logic [7:0]  fixed_pattern;
  logic [31:0] burst_len;
  logic [7:0]  tdata;
  logic        tvalid;
  logic        tready;
  logic        busy;
  logic        done;
  logic [31:0] word_count;
`ifdef LINK_PATTERN_GEN_ERR_INJECT_EN
  logic        inject_err;
  logic [31:0] inject_count;
`endif

  int checks   = 0;
  int failures = 0;

  link_pattern_gen #(
    .COUNTER_WIDTH (32),
    .PRBS_SEED     (7'h7F)
  ) dut (
    .clk160        (clk160),
    .rst           (rst),
    .start         (start),
    .stop          (stop),
    .mode          (mode),
    .fixed_pattern (fixed_pattern),
    .burst_len     (burst_len),
    .tdata         (tdata),
    .tvalid        (tvalid),
    .tready        (tready),
    .busy          (busy),
    .done          (done),
    .word_count    (word_count)
`ifdef LINK_PATTERN_GEN_ERR_INJECT_EN
    ,
    .inject_err    (inject_err),
    .inject_count  (inject_count)
`endif
  );

  initial clk160 = 1'b0;
  always #5 clk160 = ~clk160;

  task automatic cyc();
    @(posedge clk160);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [7:0] exp8;
    int         acc;

    rst           = 1'b1;
    start         = 1'b0;
    stop          = 1'b0;
    mode          = 2'd0;
    fixed_pattern = 8'h00;
    burst_len     = 32'd0;
    tready        = 1'b0;
`ifdef LINK_PATTERN_GEN_ERR_INJECT_EN
    inject_err    = 1'b0;
`endif

    #12;
    chk("rst_tvalid", {31'b0, tvalid}, 32'd0);
    chk("rst_tdata", {24'b0, tdata}, 32'h00);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_wc", word_count, 32'd0);
    rst = 1'b0;

    // PRBS7 bounded burst of three words
    cyc();
    mode = 2'd1; burst_len = 32'd3; tready = 1'b1; start = 1'b1;
    cyc();
    start = 1'b0;
    #1;
    chk("prbs_vld", {31'b0, tvalid}, 32'd1);
    chk("prbs_w1", {24'b0, tdata}, 32'h40);
    chk("prbs_done0", {31'b0, done}, 32'd0);
    chk("prbs_busy", {31'b0, busy}, 32'd1);
    cyc(); #1;
    chk("prbs_w2", {24'b0, tdata}, 32'h30);
    chk("prbs_wc1", word_count, 32'd1);
    cyc(); #1;
    chk("prbs_w3", {24'b0, tdata}, 32'h14);
    chk("prbs_done", {31'b0, done}, 32'd1);
    chk("prbs_wc2", word_count, 32'd2);
    cyc(); #1;
    chk("prbs_end_vld", {31'b0, tvalid}, 32'd0);
    chk("prbs_end_done", {31'b0, done}, 32'd0);
    chk("prbs_end_busy", {31'b0, busy}, 32'd0);
    chk("prbs_end_wc", word_count, 32'd3);
    cyc(); #1;
    chk("prbs_hold_wc", word_count, 32'd3);

    // Continuous counting with alternating backpressure, then stop
    mode = 2'd2; burst_len = 32'd0; tready = 1'b0; start = 1'b1;
    cyc();
    start = 1'b0;
    exp8 = 8'h00;
    acc  = 0;
    for (int i = 0; i < 1000 && acc < 300; i++) begin
      cyc();
      tready = (i % 2 == 0);
      #1;
      chk("cnt_vld", {31'b0, tvalid}, 32'd1);
      chk("cnt_data", {24'b0, tdata}, {24'b0, exp8});
      chk("cnt_wc", word_count, acc);
      if (tready) begin
        exp8 = exp8 + 8'd1;
        acc++;
      end
    end
    chk("cnt_accepted", acc, 32'd300);
    cyc();
    tready = 1'b1; stop = 1'b1;
    #1;
    chk("cnt_stop_data", {24'b0, tdata}, 32'h2C);
    chk("cnt_stop_done", {31'b0, done}, 32'd0);
    cyc();
    stop = 1'b0; tready = 1'b0;
    #1;
    chk("cnt_stop_vld", {31'b0, tvalid}, 32'd0);
    chk("cnt_stop_busy", {31'b0, busy}, 32'd0);
    chk("cnt_stop_wc", word_count, 32'd301);

    // Toggle burst; mid-burst input changes must not leak in
    cyc();
    mode = 2'd3; fixed_pattern = 8'hA5; burst_len = 32'd4; tready = 1'b1; start = 1'b1;
    cyc();
    start = 1'b0;
    #1;
    chk("tog_w1", {24'b0, tdata}, 32'hA5);
    fixed_pattern = 8'h00; mode = 2'd0; burst_len = 32'd2;
    cyc(); #1;
    chk("tog_w2", {24'b0, tdata}, 32'h5A);
    chk("tog_done_early", {31'b0, done}, 32'd0);
    cyc(); #1;
    chk("tog_w3", {24'b0, tdata}, 32'hA5);
    cyc(); #1;
    chk("tog_w4", {24'b0, tdata}, 32'h5A);
    chk("tog_done", {31'b0, done}, 32'd1);
    cyc(); #1;
    chk("tog_end_vld", {31'b0, tvalid}, 32'd0);
    chk("tog_end_wc", word_count, 32'd4);

    // Stop under backpressure: word held until accepted, then IDLE
    mode = 2'd2; burst_len = 32'd0; tready = 1'b1; start = 1'b1;
    cyc();
    start = 1'b0;
    #1;
    chk("bp_w0", {24'b0, tdata}, 32'h00);
    cyc(); #1;
    chk("bp_w1", {24'b0, tdata}, 32'h01);
    tready = 1'b0; stop = 1'b1;
    cyc();
    stop = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_hold_vld", {31'b0, tvalid}, 32'd1);
      chk("bp_hold_data", {24'b0, tdata}, 32'h01);
      chk("bp_hold_busy", {31'b0, busy}, 32'd1);
      cyc();
    end
    tready = 1'b1;
    #1;
    chk("bp_last_data", {24'b0, tdata}, 32'h01);
    chk("bp_last_wc", word_count, 32'd1);
    cyc(); #1;
    chk("bp_end_vld", {31'b0, tvalid}, 32'd0);
    chk("bp_end_busy", {31'b0, busy}, 32'd0);
    chk("bp_end_wc", word_count, 32'd2);

    // start together with stop in IDLE: nothing happens
    start = 1'b1; stop = 1'b1;
    cyc();
    start = 1'b0; stop = 1'b0;
    #1;
    chk("ss_busy", {31'b0, busy}, 32'd0);
    chk("ss_wc", word_count, 32'd2);

    // start in RUN ignored, then async reset mid-burst and PRBS restart
    cyc();
    mode = 2'd1; burst_len = 32'd0; tready = 1'b1; start = 1'b1;
    cyc();
    start = 1'b0;
    #1;
    chk("rr_w1", {24'b0, tdata}, 32'h40);
    cyc();
    start = 1'b1;
    #1;
    chk("rr_w2", {24'b0, tdata}, 32'h30);
    cyc();
    start = 1'b0;
    #1;
    chk("rr_w3", {24'b0, tdata}, 32'h14);
    chk("rr_wc", word_count, 32'd2);
    #1;
    rst = 1'b1;
    #1;
    chk("rr_rst_vld", {31'b0, tvalid}, 32'd0);
    chk("rr_rst_wc", word_count, 32'd0);
    chk("rr_rst_busy", {31'b0, busy}, 32'd0);
    chk("rr_rst_data", {24'b0, tdata}, 32'h00);
    #1;
    rst = 1'b0;
    cyc();
    start = 1'b1;
    cyc();
    start = 1'b0;
    #1;
    chk("rr_restart_w1", {24'b0, tdata}, 32'h40);
    chk("rr_restart_wc", word_count, 32'd0);
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    #1;
    chk("rr_stop_busy", {31'b0, busy}, 32'd0);
    chk("rr_stop_wc", word_count, 32'd1);

`ifdef LINK_PATTERN_GEN_ERR_INJECT_EN
    // One corrupted word despite two pulses, generator continues clean
    cyc();
    mode = 2'd0; fixed_pattern = 8'h00; burst_len = 32'd0; tready = 1'b0; start = 1'b1;
    cyc();
    start = 1'b0;
    #1;
    chk("inj_clean0", {24'b0, tdata}, 32'h00);
    inject_err = 1'b1;
    cyc();
    #1;
    chk("inj_corrupt_a", {24'b0, tdata}, 32'h01);
    cyc();
    inject_err = 1'b0; tready = 1'b1;
    #1;
    chk("inj_corrupt_b", {24'b0, tdata}, 32'h01);
    chk("inj_cnt0", inject_count, 32'd0);
    cyc();
    tready = 1'b0;
    #1;
    chk("inj_clean1", {24'b0, tdata}, 32'h00);
    chk("inj_cnt1", inject_count, 32'd1);
    chk("inj_wc", word_count, 32'd1);
    tready = 1'b1; stop = 1'b1;
    cyc();
    stop = 1'b0;
    #1;
    chk("inj_end_busy", {31'b0, busy}, 32'd0);
    chk("inj_end_cnt", inject_count, 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
